// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
package mux_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  // Select width; a single bit is kept even for degenerate channel counts.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from ptr, or fixed priority (lowest index wins).
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned MODE   = MODE_RR,
  localparam int unsigned SEL_W = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    // Scan from lowest priority to highest so the last hit is the winner.
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      if (MODE == MODE_FIXED) begin
        idx = SEL_W'(off);
      end else begin
        idx = SEL_W'((ptr + off) % NUM_CH);
      end
      if (req[idx]) begin
        grant_idx = idx;
      end
    end
    if (|req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream multiplexer with internal arbitration, optional packet lock and a
// registered output stage that reloads while draining for full throughput.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODE     = MODE_RR,
  parameter bit          LOCK_PKT = 1'b1,
  localparam int unsigned SEL_W   = sel_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] src;
  logic [SEL_W-1:0] src_next;
  logic             slot_free;
  logic             req_hit;
  logic             accept;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_ch_d = lock_ch_q;
    in_ready  = '0;
    slot_free = !out_valid || out_ready;
    src       = (state_q == LOCKED) ? lock_ch_q : grant_idx;
    src_next  = (src == SEL_W'(NUM_CH - 1)) ? '0 : src + 1'b1;
    req_hit   = (state_q == LOCKED) ? in_valid[lock_ch_q] : |grant;
    accept    = rst_n && slot_free && req_hit;
    if (accept) begin
      in_ready[src] = 1'b1;
      if (LOCK_PKT && !in_last[src]) begin
        state_d   = LOCKED;
        lock_ch_d = src;
      end else begin
        state_d  = IDLE;
        rr_ptr_d = src_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data[src*WIDTH +: WIDTH];
        out_last  <= in_last[src];
        out_sel   <= src;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: three instances (RR+lock, fixed+lock, RR no-lock) driven
// from per-channel producer queues and checked against a transaction-level model.
module tb_rr_stream_mux;
  import mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int QD = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] in_data   [K];
  logic [N-1:0]   in_valid  [K];
  logic [N-1:0]   in_last   [K];
  logic [N-1:0]   in_ready  [K];
  logic [W-1:0]   out_data  [K];
  logic           out_valid [K];
  logic           out_last  [K];
  logic [1:0]     out_sel   [K];
  logic           out_ready [K];

  always #5 clk = ~clk;

  for (genvar g = 0; g < K; g++) begin : g_dut
    rr_stream_mux #(
      .NUM_CH   (N),
      .WIDTH    (W),
      .MODE     ((g == 1) ? MODE_FIXED : MODE_RR),
      .LOCK_PKT (g != 2)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_last   (in_last[g]),
      .in_ready  (in_ready[g]),
      .out_data  (out_data[g]),
      .out_valid (out_valid[g]),
      .out_last  (out_last[g]),
      .out_sel   (out_sel[g]),
      .out_ready (out_ready[g])
    );
  end

  // Producer queues: {last, data} per beat.
  logic [W:0] qmem [K][N][QD];
  int         hd   [K][N];
  int         tl   [K][N];
  logic       en   [K][N];

  // Reference model state.
  int         m_locked [K];
  int         m_lock   [K];
  int         m_ptr    [K];
  int         m_g      [K];
  int         m_os     [K];
  logic       m_ov     [K];
  logic       m_ol     [K];
  logic [W-1:0] m_od   [K];

  int checks = 0;
  int passes = 0;

  function automatic int mode_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int lock_of(int k);
    return (k != 2) ? 1 : 0;
  endfunction

  task automatic push(int k, int c, logic [W-1:0] d, logic l);
    qmem[k][c][tl[k][c] % QD] = {l, d};
    tl[k][c]++;
  endtask

  // Channel the model expects to be accepted this cycle, or -1.
  function automatic int pick(int k);
    if (!rst_n) return -1;
    if (m_ov[k] && !out_ready[k]) return -1;
    if (m_locked[k] != 0) return in_valid[k][m_lock[k]] ? m_lock[k] : -1;
    for (int o = 0; o < N; o++) begin
      int c;
      c = (mode_of(k) != 0) ? o : (m_ptr[k] + o) % N;
      if (in_valid[k][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy(int k);
    logic [N-1:0] r;
    r = '0;
    if (m_g[k] >= 0) r[m_g[k]] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(int c);
    logic [N-1:0] r;
    r = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  task automatic model_clear(int k);
    m_locked[k] = 0;
    m_lock[k]   = 0;
    m_ptr[k]    = 0;
    m_g[k]      = -1;
    m_ov[k]     = 1'b0;
    m_od[k]     = '0;
    m_ol[k]     = 1'b0;
    m_os[k]     = 0;
  endtask

  // Drive producer heads at the falling edge, then predict the grant.
  task automatic apply();
    @(negedge clk);
    for (int k = 0; k < K; k++) begin
      for (int c = 0; c < N; c++) begin
        logic v;
        v = (hd[k][c] != tl[k][c]) && en[k][c];
        in_valid[k][c] = v;
        {in_last[k][c], in_data[k][c*W +: W]} = v ? qmem[k][c][hd[k][c] % QD] :
                                                    {1'b0, W'($urandom)};
      end
    end
    for (int k = 0; k < K; k++) m_g[k] = pick(k);
    #2;
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < K; k++) begin
      if (!rst_n) begin
        model_clear(k);
      end else if (m_g[k] >= 0) begin
        int g;
        logic [W:0] b;
        g = m_g[k];
        b = qmem[k][g][hd[k][g] % QD];
        hd[k][g]++;
        m_ov[k] = 1'b1;
        m_od[k] = b[W-1:0];
        m_ol[k] = b[W];
        m_os[k] = g;
        if (lock_of(k) == 0 || b[W]) begin
          m_locked[k] = 0;
          m_ptr[k]    = (g + 1) % N;
        end else begin
          m_locked[k] = 1;
          m_lock[k]   = g;
        end
      end else if (out_ready[k]) begin
        m_ov[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < K; k++) begin
      out_ready[k] = 1'b1;
      for (int c = 0; c < N; c++) begin
        hd[k][c] = 0;
        tl[k][c] = 0;
        en[k][c] = 1'b1;
      end
    end
    rst_n = 1'b0;
    apply();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) push(0, c, W'(8'h10 + c), 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply();
      checks++;
      if (in_ready[0] !== 4'b0000)
        $display("FAIL reset_in_ready cyc%0d got %b want 0000", i, in_ready[0]);
      else passes++;
      tick();
      checks++;
      if (out_valid[0] !== 1'b0 || out_data[0] !== 8'h00)
        $display("FAIL reset_out cyc%0d got v=%b d=%h want v=0 d=00", i, out_valid[0],
                 out_data[0]);
      else passes++;
    end
    rst_n = 1'b1;
    apply();
    checks++;
    if (in_ready[0] !== 4'b0001)
      $display("FAIL reset_first_ready got %b want 0001", in_ready[0]);
    else passes++;
    tick();
    checks++;
    if (out_valid[0] !== 1'b1 || out_sel[0] !== 2'd0 || out_data[0] !== 8'h10)
      $display("FAIL reset_first_beat got v=%b sel=%0d d=%h want v=1 sel=0 d=10",
               out_valid[0], out_sel[0], out_data[0]);
    else passes++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < N; c++) push(0, c, W'(c * 16 + b), 1'b1);
    for (int i = 0; i < 2 * N; i++) begin
      apply();
      checks++;
      if (in_ready[0] !== onehot(i % N))
        $display("FAIL rr_ready beat%0d got %b want %b", i, in_ready[0], onehot(i % N));
      else passes++;
      tick();
      checks++;
      if (out_valid[0] !== 1'b1 || out_sel[0] !== 2'(i % N) ||
          out_data[0] !== W'((i % N) * 16 + i / N))
        $display("FAIL rr_out beat%0d got v=%b sel=%0d d=%h want v=1 sel=%0d d=%h", i,
                 out_valid[0], out_sel[0], out_data[0], i % N, W'((i % N) * 16 + i / N));
      else passes++;
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] ed [6];
    int           es [6];
    logic         el [6];
    ed = '{8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hC1, 8'h02};
    es = '{0, 1, 1, 1, 2, 0};
    el = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    push(0, 0, 8'h01, 1'b1);
    push(0, 0, 8'h02, 1'b1);
    push(0, 1, 8'hA1, 1'b0);
    push(0, 1, 8'hA2, 1'b0);
    push(0, 1, 8'hA3, 1'b1);
    push(0, 2, 8'hC1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      apply();
      checks++;
      if (in_ready[0] !== onehot(es[i]))
        $display("FAIL lock_ready beat%0d got %b want %b", i, in_ready[0], onehot(es[i]));
      else passes++;
      tick();
      checks++;
      if (out_valid[0] !== 1'b1 || out_sel[0] !== 2'(es[i]) || out_data[0] !== ed[i] ||
          out_last[0] !== el[i])
        $display("FAIL lock_out beat%0d got sel=%0d d=%h l=%b want sel=%0d d=%h l=%b", i,
                 out_sel[0], out_data[0], out_last[0], es[i], ed[i], el[i]);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got [$];
    do_reset();
    for (int i = 0; i < 8; i++) push(0, 2, W'(8'h50 + i), 1'b1);
    for (int i = 0; i < 2; i++) begin
      apply();
      if (out_valid[0] && out_ready[0]) got.push_back(out_data[0]);
      tick();
    end
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply();
      checks++;
      if (in_ready[0] !== 4'b0000)
        $display("FAIL bp_ready cyc%0d got %b want 0000", i, in_ready[0]);
      else passes++;
      tick();
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h51)
        $display("FAIL bp_hold cyc%0d got v=%b d=%h want v=1 d=51", i, out_valid[0],
                 out_data[0]);
      else passes++;
    end
    out_ready[0] = 1'b1;
    for (int i = 0; i < 20 && got.size() < 8; i++) begin
      apply();
      if (out_valid[0] && out_ready[0]) got.push_back(out_data[0]);
      tick();
    end
    checks++;
    if (got.size() != 8) $display("FAIL bp_count got %0d want 8", got.size());
    else passes++;
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== W'(8'h50 + i))
        $display("FAIL bp_order beat%0d got %h want %h", i, got[i], W'(8'h50 + i));
      else passes++;
    end
  endtask

  task automatic test_fixed();
    do_reset();
    for (int i = 0; i < 5; i++) push(1, 0, W'(i), 1'b1);
    for (int i = 0; i < 2; i++) push(1, 3, W'(8'h30 + i), 1'b1);
    for (int i = 0; i < 7; i++) begin
      int e;
      e = (i < 5) ? 0 : 3;
      apply();
      checks++;
      if (in_ready[1] !== onehot(e))
        $display("FAIL fixed_ready cyc%0d got %b want %b", i, in_ready[1], onehot(e));
      else passes++;
      tick();
      checks++;
      if (out_valid[1] !== 1'b1 || out_sel[1] !== 2'(e))
        $display("FAIL fixed_sel cyc%0d got v=%b sel=%0d want v=1 sel=%0d", i,
                 out_valid[1], out_sel[1], e);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push(0, 2, 8'h21, 1'b0);
    push(0, 2, 8'h22, 1'b0);
    push(0, 2, 8'h23, 1'b1);
    apply();
    tick();
    rst_n = 1'b0;
    apply();
    checks++;
    if (in_ready[0] !== 4'b0000)
      $display("FAIL midrst_ready got %b want 0000", in_ready[0]);
    else passes++;
    tick();
    checks++;
    if (out_valid[0] !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid[0]);
    else passes++;
    rst_n = 1'b1;
    push(0, 0, 8'h0A, 1'b1);
    apply();
    checks++;
    if (in_ready[0] !== 4'b0001)
      $display("FAIL midrst_regrant got %b want 0001", in_ready[0]);
    else passes++;
    tick();
    checks++;
    if (out_sel[0] !== 2'd0 || out_data[0] !== 8'h0A)
      $display("FAIL midrst_out got sel=%0d d=%h want sel=0 d=0a", out_sel[0], out_data[0]);
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < K; k++) begin
        for (int c = 0; c < N; c++) begin
          if (($urandom % 4) == 0 && (tl[k][c] - hd[k][c]) < 200)
            push(k, c, W'($urandom), ($urandom % 3) == 0);
          en[k][c] = ($urandom % 4) != 0;
        end
        out_ready[k] = ($urandom % 4) != 0;
      end
      apply();
      for (int k = 0; k < K; k++) begin
        checks++;
        if (in_ready[k] !== exp_rdy(k))
          $display("FAIL rand_ready dut%0d cyc%0d got %b want %b", k, cyc, in_ready[k],
                   exp_rdy(k));
        else passes++;
      end
      tick();
      for (int k = 0; k < K; k++) begin
        checks++;
        if (out_valid[k] !== m_ov[k])
          $display("FAIL rand_valid dut%0d cyc%0d got %b want %b", k, cyc, out_valid[k],
                   m_ov[k]);
        else passes++;
        if (m_ov[k]) begin
          checks++;
          if (out_data[k] !== m_od[k] || out_last[k] !== m_ol[k] || out_sel[k] !== 2'(m_os[k]))
            $display("FAIL rand_beat dut%0d cyc%0d got d=%h l=%b s=%0d want d=%h l=%b s=%0d",
                     k, cyc, out_data[k], out_last[k], out_sel[k], m_od[k], m_ol[k], m_os[k]);
          else passes++;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < K; k++) begin
      out_ready[k] = 1'b1;
      in_valid[k]  = '0;
      in_last[k]   = '0;
      in_data[k]   = '0;
      model_clear(k);
      for (int c = 0; c < N; c++) begin
        hd[k][c] = 0;
        tl[k][c] = 0;
        en[k][c] = 1'b1;
      end
    end
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_fixed();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
